// File: rtl/decoder_pkg.sv
// Shared types and constants for the decoder_scan select-vector generator.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_dec.sv
// Combinational index decoder: one-hot or thermometer vector plus an out-of-range flag.
module onehot_dec #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8
) (
    input  logic [SEL_W-1:0]   sel_i,
    input  logic               thermo_i,
    output logic [NUM_OUT-1:0] vec_o,
    output logic               range_err_o
);

    always_comb begin
        vec_o       = '0;
        range_err_o = (int'(sel_i) >= NUM_OUT);
        // An illegal index must never light any output.
        if (!range_err_o) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                vec_o[i] = thermo_i ? (i <= int'(sel_i)) : (i == int'(sel_i));
            end
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered select-vector generator: direct index decode or auto-scan with programmable dwell.
// Define DECODER_THERMO_EN to add the thermo input (thermometer code in direct mode).
//
// state  | meaning
// IDLE   | disabled or waiting for the first index; all outputs low
// DIRECT | out holds the decode of the last accepted index
// SCAN   | one-hot bit walks 0..NUM_OUT-1, each step held dwell+1 cycles
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               in_vld,
    input  logic [SEL_W-1:0]   in_sel,
    output logic               in_rdy,
`ifdef DECODER_THERMO_EN
    input  logic               thermo,
`endif
    input  logic [DWELL_W-1:0] dwell,
    output logic [NUM_OUT-1:0] out,
    output logic               out_vld,
    output logic               err,
    output logic               scan_wrap
);

    state_t               state_q, state_d;
    logic [NUM_OUT-1:0]   out_q, out_d;
    logic                 out_vld_q, out_vld_d;
    logic                 err_q, err_d;
    logic                 wrap_q, wrap_d;
    logic [SEL_W-1:0]     idx_q, idx_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;

    logic                 scan_mode;
    logic                 idx_last;
    logic [SEL_W-1:0]     idx_step;
    logic                 thermo_w;
    logic [SEL_W-1:0]     dec_sel;
    logic                 dec_thermo;
    logic [NUM_OUT-1:0]   dec_vec;
    logic                 dec_err;

`ifdef DECODER_THERMO_EN
    assign thermo_w = thermo;
`else
    assign thermo_w = 1'b0;
`endif

    assign scan_mode = (mode == MODE_SCAN);
    assign in_rdy    = en & (mode == MODE_DIRECT);
    assign idx_last  = (idx_q == SEL_W'(NUM_OUT - 1));
    assign idx_step  = idx_last ? '0 : idx_q + 1'b1;

    // Scan index and dwell down-counter; the counter reloads from dwell at each step start.
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (!en || !scan_mode) begin
            idx_d = '0;
            cnt_d = '0;
        end else if (state_q != SCAN) begin
            idx_d = '0;
            cnt_d = dwell;
        end else if (cnt_q == '0) begin
            idx_d  = idx_step;
            cnt_d  = dwell;
            wrap_d = idx_last;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // The decoder serves both paths: scan decodes the upcoming index, direct the presented one.
    assign dec_sel    = scan_mode ? idx_d : in_sel;
    assign dec_thermo = ~scan_mode & thermo_w;

    onehot_dec #(
        .SEL_W   (SEL_W),
        .NUM_OUT (NUM_OUT)
    ) u_dec (
        .sel_i       (dec_sel),
        .thermo_i    (dec_thermo),
        .vec_o       (dec_vec),
        .range_err_o (dec_err)
    );

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        out_vld_d = out_vld_q;
        err_d     = err_q;
        if (!en) begin
            state_d   = IDLE;
            out_d     = '0;
            out_vld_d = 1'b0;
            err_d     = 1'b0;
        end else if (scan_mode) begin
            state_d   = SCAN;
            out_d     = dec_vec;
            out_vld_d = 1'b1;
            err_d     = 1'b0;
        end else if (in_vld) begin
            state_d   = DIRECT;
            out_d     = dec_vec;
            out_vld_d = ~dec_err;
            err_d     = dec_err;
        end else if (state_q == SCAN) begin
            // Leaving scan with no index pending: drop the walking bit at once.
            state_d   = DIRECT;
            out_d     = '0;
            out_vld_d = 1'b0;
            err_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            err_q     <= 1'b0;
            wrap_q    <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            err_q     <= err_d;
            wrap_q    <= wrap_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out       = out_q;
    assign out_vld   = out_vld_q;
    assign err       = err_q;
    assign scan_wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: an 8-output and a 6-output instance driven in lockstep.
module tb_decoder_scan;

    typedef struct {
        logic [10:0] a;
        logic [8:0]  b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       in_vld = 1'b0;
    logic [2:0] in_sel = '0;
    logic [3:0] dwell = '0;
    logic       thermo = 1'b0;

    logic       rdy8, vld8, err8, wrap8;
    logic [7:0] out8;
    logic       rdy6, vld6, err6, wrap6;
    logic [5:0] out6;

    int n_chk = 0;
    int n_bad = 0;
    exp_t sb[$];

    int         m_st[2], m_idx[2], m_cnt[2];
    logic [7:0] m_out[2];
    logic       m_vld[2], m_err[2], m_wrap[2];
    int         nn[2] = '{8, 6};

    always #5 clk = ~clk;

    decoder_scan #(.SEL_W(3), .NUM_OUT(8), .DWELL_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_vld(in_vld), .in_sel(in_sel),
        .in_rdy(rdy8),
`ifdef DECODER_THERMO_EN
        .thermo(thermo),
`endif
        .dwell(dwell), .out(out8), .out_vld(vld8), .err(err8), .scan_wrap(wrap8)
    );

    decoder_scan #(.SEL_W(3), .NUM_OUT(6), .DWELL_W(4)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_vld(in_vld), .in_sel(in_sel),
        .in_rdy(rdy6),
`ifdef DECODER_THERMO_EN
        .thermo(thermo),
`endif
        .dwell(dwell), .out(out6), .out_vld(vld6), .err(err6), .scan_wrap(wrap6)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_idx[k] = 0; m_cnt[k] = 0;
            m_out[k] = '0; m_vld[k] = 1'b0; m_err[k] = 1'b0; m_wrap[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        int  n;
        logic th;
        n = nn[k];
`ifdef DECODER_THERMO_EN
        th = thermo;
`else
        th = 1'b0;
`endif
        m_wrap[k] = 1'b0;
        if (!en) begin
            m_st[k] = 0; m_idx[k] = 0; m_cnt[k] = 0;
            m_out[k] = '0; m_vld[k] = 1'b0; m_err[k] = 1'b0;
        end else if (mode) begin
            if (m_st[k] != 2) begin
                m_st[k] = 2; m_idx[k] = 0; m_cnt[k] = int'(dwell);
            end else if (m_cnt[k] == 0) begin
                m_wrap[k] = (m_idx[k] == n - 1);
                m_idx[k] = m_wrap[k] ? 0 : m_idx[k] + 1;
                m_cnt[k] = int'(dwell);
            end else begin
                m_cnt[k]--;
            end
            m_out[k] = 8'(1 << m_idx[k]);
            m_vld[k] = 1'b1;
            m_err[k] = 1'b0;
        end else begin
            m_idx[k] = 0; m_cnt[k] = 0;
            if (in_vld) begin
                m_st[k] = 1;
                if (int'(in_sel) < n) begin
                    m_out[k] = th ? 8'((2 << in_sel) - 1) : 8'(1 << in_sel);
                    m_vld[k] = 1'b1; m_err[k] = 1'b0;
                end else begin
                    m_out[k] = '0; m_vld[k] = 1'b0; m_err[k] = 1'b1;
                end
            end else if (m_st[k] == 2) begin
                m_st[k] = 1;
                m_out[k] = '0; m_vld[k] = 1'b0; m_err[k] = 1'b0;
            end
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        exp_t e;
        #1;
        chk("in_rdy8", rdy8, en & ~mode);
        chk("in_rdy6", rdy6, en & ~mode);
        model_step(0);
        model_step(1);
        e.a = {m_out[0], m_vld[0], m_err[0], m_wrap[0]};
        e.b = {m_out[1][5:0], m_vld[1], m_err[1], m_wrap[1]};
        sb.push_back(e);
        @(posedge clk);
        #1;
        chk("sb_depth", sb.size(), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("dut8", {out8, vld8, err8, wrap8}, e.a);
            chk("dut6", {out6, vld6, err6, wrap6}, e.b);
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic e_i, input logic m_i, input logic v_i,
                         input logic [2:0] s_i, input logic [3:0] d_i);
        en = e_i; mode = m_i; in_vld = v_i; in_sel = s_i; dwell = d_i;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out8", {out8, vld8, err8, wrap8}, '0);
        chk("rst_out6", {out6, vld6, err6, wrap6}, '0);
        rst_n = 1'b1;
        tick();

        // Direct decode and hold
        drive(1, 0, 1, 3'd5, 0); tick();
        drive(1, 0, 0, 3'd0, 0); repeat (3) tick();
        chk("direct5_hold", out8, 8'b0010_0000);

        // Out of range on the 6-output instance, then recovery
        drive(1, 0, 1, 3'd7, 0); tick();
        chk("oor_err6", {out6, err6}, {6'd0, 1'b1});
        drive(1, 0, 1, 3'd2, 0); tick();
        chk("recover6", {out6, err6}, {6'b000100, 1'b0});

        // Back-to-back accepts
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 1, 3'(i), 0); tick();
        end
        drive(1, 0, 0, 3'd0, 0); tick();

        // Full scan with dwell=2 through a wrap
        drive(1, 1, 0, 3'd0, 4'd2);
        for (int i = 0; i < 8 * 3 + 6; i++) tick();

        // Abort mid-scan with an index presented in the same cycle
        drive(1, 0, 0, 3'd0, 0); tick();
        drive(1, 1, 0, 3'd0, 4'd1);
        for (int i = 0; i < 40 && m_out[0] != 8'h08; i++) tick();
        chk("reach_08", out8, 8'h08);
        drive(1, 0, 1, 3'd1, 4'd1); tick();
        chk("abort_sel1", {out8, vld8}, {8'h02, 1'b1});
        drive(1, 1, 0, 3'd0, 4'd3); tick();
        drive(1, 0, 0, 3'd0, 4'd3); tick();
        chk("abort_clear", {out8, vld8}, {8'h00, 1'b0});

        // Dwell changed mid-step only takes effect at the next step
        drive(1, 1, 0, 3'd0, 4'd3); tick(); tick();
        dwell = 4'd0; repeat (8) tick();

        // Drop en mid-scan
        drive(0, 1, 0, 3'd0, 0); tick();
        chk("en_low_clear", {out8, vld8, wrap8}, '0);

        // Asynchronous reset mid-scan, between edges
        drive(1, 1, 0, 3'd0, 4'd1); repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst8", {out8, vld8, err8, wrap8}, '0);
        chk("async_rst6", {out6, vld6, err6, wrap6}, '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 1, 3'd4, 0); tick();

`ifdef DECODER_THERMO_EN
        thermo = 1'b1; drive(1, 0, 1, 3'd3, 0); tick();
        chk("thermo3", out8, 8'b0000_1111);
        thermo = 1'b0; drive(1, 0, 1, 3'd3, 0); tick();
        chk("onehot3", out8, 8'b0000_1000);
        thermo = 1'b1; drive(1, 1, 0, 3'd0, 0); repeat (3) tick();
        thermo = 1'b0;
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) == 0) ? ~mode : mode,
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)));
`ifdef DECODER_THERMO_EN
            thermo = 1'($urandom_range(0, 1));
`endif
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/decoder_scan.md
Name: decoder_scan

Overview:
- Registered, parametrised SEL_W-to-NUM_OUT decoder.
- Mode 0 (direct): converts a handshaken index into a one-hot output vector.
- Mode 1 (scan): walks the one-hot bit across all outputs with a programmable dwell.
- Used for channel/row select, LED and keypad scanning, and mux enables wherever a held, glitch-free select vector is needed.

Parameters:
- SEL_W, 3, width of the index input.
- NUM_OUT, 8, number of outputs; legal range 2..2^SEL_W (non-power-of-two allowed).
- DWELL_W, 4, width of the dwell-count input.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  block enable.
- mode  input  1  0 = direct decode, 1 = auto-scan.
- in_vld  input  1  index valid.
- in_sel  input  SEL_W  index to decode.
- in_rdy  output  1  index accepted when in_vld & in_rdy.
- dwell  input  DWELL_W  scan: each output held dwell+1 cycles.
- out  output  NUM_OUT  registered one-hot select vector.
- out_vld  output  1  out holds a valid selection.
- err  output  1  last accepted index was out of range.
- scan_wrap  output  1  one-cycle pulse on scan wrap-around.

Behaviour:
- Interface (decided): one clock, clk; reset is asynchronous, active-low, rst_n.
- Reset values: out=0, out_vld=0, err=0, scan_wrap=0; FSM in IDLE; scan index=0; dwell counter=0.
- in_rdy is combinational: in_rdy = en & ~mode. It is independent of in_vld, so there are no combinational loops.
- All other outputs are registered.
- FSM states: IDLE, DIRECT, SCAN.
  - IDLE -> DIRECT: en & ~mode & in_vld.
  - IDLE -> SCAN: en & mode.
  - DIRECT -> SCAN: en & mode.
  - SCAN -> DIRECT: en & ~mode.
  - any -> IDLE: ~en.
- Direct mode, 1-cycle latency:
  - An accept at edge N shows on out from edge N+1.
  - With in_sel < NUM_OUT: out = 1 << in_sel, out_vld=1, err=0.
  - With in_sel >= NUM_OUT: out=0, out_vld=0, err=1.
  - out, out_vld and err hold until the next accept or a state change.
  - Back-to-back accepts every cycle are supported.
- Scan mode:
  - On entry, index=0 and out=1 from the next cycle, out_vld=1.
  - dwell is sampled when each step starts; that step lasts dwell+1 cycles.
  - Changing dwell mid-step has no effect until the next step.
  - The index advances 0..NUM_OUT-1, then wraps to 0.
  - scan_wrap=1 only in the first cycle index 0 is shown after a wrap, not on initial entry.
  - err=0 throughout scan mode.
- Mode change mid-scan:
  - 1->0 aborts immediately: next cycle out=0, out_vld=0, state DIRECT.
  - An index presented in the same cycle as the mode 1->0 change is accepted if in_rdy=1, and its decode appears in the following cycle.
- en low (any state): next cycle out=0, out_vld=0, err=0, scan_wrap=0; index and dwell counter cleared.
- Reset asserted mid-operation: all outputs clear immediately (asynchronous). The first activity after release follows the rules above.

Optional Feature:
- Macro: DECODER_THERMO_EN.
- Defined:
  - Adds input port thermo (1 bit).
  - In direct mode with thermo=1, a legal in_sel=k gives out bits [k:0]=1 (thermometer code).
  - Out-of-range and scan behaviour are unchanged; scan remains one-hot.
  - thermo is sampled with the accept.
- Not defined: the port is absent and direct mode is one-hot only.

Decomposition:
- Package decoder_pkg holds:
  - state typedef (IDLE/DIRECT/SCAN);
  - mode constants MODE_DIRECT=0, MODE_SCAN=1.
- One combinational sub-module, onehot_dec (parameters SEL_W, NUM_OUT):
  - produces the one-hot/thermometer vector and the range-error flag;
  - is shared by the direct and scan paths.
- The top level holds the FSM, dwell counter, index counter and output registers.

Test Plan:
- Reset, then en=1, mode=0, in_vld=1, in_sel=5 for one cycle -> next cycle out=8'b0010_0000, out_vld=1, err=0; the value holds with in_vld=0.
- NUM_OUT=6, in_sel=7 accepted -> next cycle out=0, out_vld=0, err=1; then in_sel=2 -> out=6'b000100, err=0.
- mode=1, dwell=2 -> out=0x01 for 3 cycles, then 0x02 ... 0x80; next 0x01 with scan_wrap=1 for exactly one cycle; in_rdy=0 throughout.
- Mid-scan at out=0x08, drop mode to 0 with in_vld=1, in_sel=1 -> in_rdy=1 that cycle, next cycle out=0x02; no residual scan bit.
- Drop en mid-scan, then assert rst_n=0 between clock edges -> out=0 next cycle; on reset, outputs clear without waiting for clk.
- With DECODER_THERMO_EN defined: thermo=1, in_sel=3 -> out=8'b0000_1111; thermo=0, in_sel=3 -> out=8'b0000_1000.
